// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, kclk glitch filter, frame FSM, FWFT byte FIFO.
// Define PS2_RX_TIMEOUT_EN to add the in-frame kclk watchdog.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                          clk_i,
    input  logic                          resetn,
    input  logic                          kclk_i,
    input  logic                          kdata_i,
    input  logic                          rd_i,
    input  logic                          clr_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic         r_kclk_m, r_kclk_s, r_kdat_m, r_kdat_s;
    logic [3:0]   r_fcnt;
    logic         r_kclk_f, r_kclk_fd;
    logic         w_edge;

    state_t       r_state;
    logic [2:0]   r_bcnt;
    logic [7:0]   r_shift;
    logic         r_par;
    logic         r_push;
    logic [7:0]   r_push_data;
    logic         r_perr, r_ferr;

    logic [7:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic         r_ovf;
    logic         w_full, w_empty, w_pop, w_wr, w_ovf;

    // Filtered kclk flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk_i) begin
        if (!resetn) begin
            r_kclk_m  <= 1'b1;
            r_kclk_s  <= 1'b1;
            r_kdat_m  <= 1'b1;
            r_kdat_s  <= 1'b1;
            r_fcnt    <= '0;
            r_kclk_f  <= 1'b1;
            r_kclk_fd <= 1'b1;
        end else begin
            r_kclk_m  <= kclk_i;
            r_kclk_s  <= r_kclk_m;
            r_kdat_m  <= kdata_i;
            r_kdat_s  <= r_kdat_m;
            r_kclk_fd <= r_kclk_f;
            if (r_kclk_s == r_kclk_f) begin
                r_fcnt <= '0;
            end else if (r_fcnt == 4'(FILTER_LEN - 1)) begin
                r_kclk_f <= r_kclk_s;
                r_fcnt   <= '0;
            end else begin
                r_fcnt <= r_fcnt + 4'd1;
            end
        end
    end

    assign w_edge = r_kclk_fd & ~r_kclk_f;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
`endif

    always_ff @(posedge clk_i) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
        end else begin
            r_push <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_edge && !r_kdat_s) begin
                        r_state <= S_DATA;
                        r_bcnt  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_edge) begin
                        r_shift <= {r_kdat_s, r_shift[7:1]};
                        r_bcnt  <= r_bcnt + 3'd1;
                        if (r_bcnt == 3'd7) r_state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (w_edge) begin
                        r_par   <= r_kdat_s;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_edge) begin
                        r_state <= S_IDLE;
                        if (!r_kdat_s) begin
                            r_ferr <= 1'b1;
                        end else if (^{r_shift, r_par}) begin
                            r_push      <= 1'b1;
                            r_push_data <= r_shift;
                        end else begin
                            r_perr <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef PS2_RX_TIMEOUT_EN
            // Watchdog: a stalled frame is abandoned; never coincides with an edge
            if (r_state == S_IDLE || w_edge) begin
                r_tcnt <= '0;
            end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_tcnt  <= '0;
                r_state <= S_IDLE;
                r_ferr  <= 1'b1;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
`endif
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = rd_i & ~w_empty;
    assign w_wr    = r_push & (~w_full | w_pop);
    assign w_ovf   = r_push & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr] <= r_push_data;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            if (w_ovf)      r_ovf <= 1'b1;
            else if (clr_i) r_ovf <= 1'b0;
        end
    end

    assign data_o       = w_empty ? 8'h00 : r_mem[r_rptr];
    assign valid_o      = ~w_empty;
    assign count_o      = r_count;
    assign overflow_o   = r_ovf;
    assign parity_err_o = r_perr;
    assign frame_err_o  = r_ferr;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames, parity/stop errors, overflow, glitch, reset.
module tb_ps2_rx_fifo;

    logic       clk_i = 1'b0;
    logic       resetn = 1'b0;
    logic       kclk_i = 1'b1;
    logic       kdata_i = 1'b1;
    logic       rd_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [3:0] count_o;
    logic       overflow_o;
    logic       parity_err_o;
    logic       frame_err_o;

    int checks = 0;
    int failures = 0;
    int perr_n = 0;
    int ferr_n = 0;

    ps2_rx_fifo #(
        .FILTER_LEN(4),
        .FIFO_DEPTH(8),
        .TIMEOUT_CYCLES(500)
    ) dut (
        .clk_i(clk_i),
        .resetn(resetn),
        .kclk_i(kclk_i),
        .kdata_i(kdata_i),
        .rd_i(rd_i),
        .clr_i(clr_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .count_o(count_o),
        .overflow_o(overflow_o),
        .parity_err_o(parity_err_o),
        .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (parity_err_o) perr_n++;
        if (frame_err_o) ferr_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b);
        kdata_i = b;
        cyc(10);
        kclk_i = 1'b0;
        cyc(20);
        kclk_i = 1'b1;
        cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stp);
        kdata_i = 1'b1;
        cyc(5);
    endtask

    task automatic pop();
        rd_i = 1'b1;
        cyc(1);
        rd_i = 1'b0;
    endtask

    int p0, f0, waited;

    initial begin
        cyc(3);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        resetn = 1'b1;
        cyc(5);

        // 0x16 has three ones, so odd parity bit is 0
        send_frame(8'h16, 1'b0, 1'b1);
        check("f16_valid", 32'(valid_o), 32'd1);
        check("f16_data", 32'(data_o), 32'h16);
        check("f16_count", 32'(count_o), 32'd1);
        pop();
        check("f16_pop_valid", 32'(valid_o), 32'd0);
        check("f16_pop_count", 32'(count_o), 32'd0);

        p0 = perr_n;
        f0 = ferr_n;
        send_frame(8'h16, 1'b1, 1'b1);
        check("perr_pulses", 32'(perr_n - p0), 32'd1);
        check("perr_count", 32'(count_o), 32'd0);
        check("perr_no_ferr", 32'(ferr_n - f0), 32'd0);

        p0 = perr_n;
        f0 = ferr_n;
        send_frame(8'h16, 1'b1, 1'b0);
        check("stop_ferr", 32'(ferr_n - f0), 32'd1);
        check("stop_no_perr", 32'(perr_n - p0), 32'd0);
        check("stop_count", 32'(count_o), 32'd0);

        for (int i = 1; i <= 9; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send_frame(b, ~^b, 1'b1);
        end
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_count", 32'(count_o), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_pop%0d", i), 32'(data_o), 32'(i));
            pop();
        end
        check("ovf_drained", 32'(valid_o), 32'd0);
        check("ovf_still_set", 32'(overflow_o), 32'd1);
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
        check("ovf_clr", 32'(overflow_o), 32'd0);

        // Low glitch one sample short of the filter length, with data low
        f0 = ferr_n;
        p0 = perr_n;
        kdata_i = 1'b0;
        cyc(5);
        kclk_i = 1'b0;
        cyc(3);
        kclk_i = 1'b1;
        cyc(20);
        kdata_i = 1'b1;
        cyc(10);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("glitch_count", 32'(count_o), 32'd1);
        check("glitch_data", 32'(data_o), 32'h1C);
        check("glitch_errs", 32'(ferr_n - f0 + perr_n - p0), 32'd0);
        pop();

        // Reset after start bit and four data bits
        f0 = ferr_n;
        p0 = perr_n;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
        cyc(5);
        check("mid_rst_count", 32'(count_o), 32'd0);
        check("mid_rst_errs", 32'(ferr_n - f0 + perr_n - p0), 32'd0);
        send_frame(8'h16, 1'b0, 1'b1);
        check("mid_rst_data", 32'(data_o), 32'h16);
        check("mid_rst_cnt1", 32'(count_o), 32'd1);
        check("mid_rst_errs2", 32'(ferr_n - f0 + perr_n - p0), 32'd0);
        pop();

`ifdef PS2_RX_TIMEOUT_EN
        f0 = ferr_n;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        waited = 0;
        while (ferr_n == f0 && waited < 2000) begin
            cyc(1);
            waited++;
        end
        // Last edge lands about 23 cycles before the final send_bit returns
        check("tmo_in_window", 32'(waited >= 440 && waited <= 510), 32'd1);
        cyc(50);
        check("tmo_pulses", 32'(ferr_n - f0), 32'd1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("tmo_next_data", 32'(data_o), 32'h1C);
        check("tmo_next_count", 32'(count_o), 32'd1);
        pop();
`else
        // Stalled frame waits; completing it afterwards still yields a byte
        f0 = ferr_n;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        cyc(1000);
        check("stall_no_ferr", 32'(ferr_n - f0), 32'd0);
        for (int i = 3; i < 8; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        kdata_i = 1'b1;
        cyc(5);
        check("stall_data", 32'(data_o), 32'h05);
        check("stall_count", 32'(count_o), 32'd1);
        pop();
        waited = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, 4, number of consecutive equal samples needed to accept a kclk level change (range 2..15).
REQ-002 SHALL have parameter FIFO_DEPTH, 8, receive FIFO entries (power of 2, range 2..64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 200000, clk_i cycles allowed between filtered kclk falling edges inside a frame.
REQ-004 SHALL have port clk_i, input, 1, system clock; the block uses this single clock only.
REQ-005 SHALL have port resetn, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port kclk_i, input, 1, asynchronous PS/2 clock from the device.
REQ-007 SHALL have port kdata_i, input, 1, asynchronous PS/2 data from the device.
REQ-008 SHALL have port rd_i, input, 1, pops the FIFO head.
REQ-009 SHALL have port clr_i, input, 1, clears overflow_o.
REQ-010 SHALL have port data_o, output, 8, FIFO head byte (first-word-fall-through).
REQ-011 SHALL have port valid_o, output, 1, FIFO not empty.
REQ-012 SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-013 SHALL have port overflow_o, output, 1, sticky flag: a byte was dropped because the FIFO was full.
REQ-014 SHALL have port parity_err_o, output, 1, one-cycle pulse marking a frame rejected for bad parity.
REQ-015 SHALL have port frame_err_o, output, 1, one-cycle pulse marking a frame rejected for bad stop bit or timeout.

Function
REQ-016 SHALL pass kclk_i and kdata_i each through a 2-FF synchroniser.
REQ-017 SHALL change filtered kclk only after FILTER_LEN consecutive equal synchronised samples; shorter pulses are ignored.
REQ-018 SHALL sample synchronised kdata on the cycle a filtered kclk 1->0 edge is detected ("edge").
REQ-019 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-020 SHALL, in IDLE, go to DATA on an edge with data=0; on an edge with data=1 it SHALL stay in IDLE.
REQ-021 SHALL, in DATA, shift 8 bits LSB first with a 3-bit counter, then go to PARITY.
REQ-022 SHALL, in PARITY, store the bit and go to STOP.
REQ-023 SHALL, in STOP, on an edge always return to IDLE and act as follows:
- stop=1 and odd parity over the 8 data bits plus parity bit: push the byte;
- stop=1 and bad parity: parity_err_o pulse, no push;
- stop=0: frame_err_o pulse only, no push, whatever the parity.
REQ-024 SHALL perform the push in the cycle after the stop edge, with valid_o/data_o updated one cycle later.
REQ-025 SHALL pop on rd_i=1 while valid_o=1, advancing data_o the next cycle; rd_i while empty SHALL be ignored.
REQ-026 SHALL drop a push when the FIFO is full with no pop, and set overflow_o.
REQ-027 SHALL accept both a push and a pop in the same cycle when the FIFO is full; count_o stays unchanged and overflow_o is not set.
REQ-028 SHALL let read/write pointers wrap modulo FIFO_DEPTH; count_o = FIFO_DEPTH when full.
REQ-029 SHALL clear overflow_o on clr_i; if clr_i coincides with an overflow event, set takes priority.

Reset
REQ-030 SHALL, when resetn=0 at a clk_i edge, clear: FSM=IDLE; bit counter and shift register=0; FIFO pointers and count_o=0; valid_o=0; data_o=0x00; overflow_o, parity_err_o and frame_err_o=0; synchronisers and filter=1 (bus idle).
REQ-031 SHALL discard a partial frame on reset mid-frame; the bits that follow SHALL be decoded from IDLE.

Configuration
REQ-032 SHALL, with PS2_RX_TIMEOUT_EN defined, count clk_i cycles while not in IDLE; the count resets on each edge, and reaching TIMEOUT_CYCLES forces IDLE with one frame_err_o pulse.
REQ-033 SHALL, without PS2_RX_TIMEOUT_EN, contain no watchdog logic; TIMEOUT_CYCLES is then ignored and a stalled frame waits indefinitely.

Verification
REQ-034 SHALL check: frame 0x16, parity 0, stop 1 -> valid_o=1, data_o=0x16, count_o=1; then rd_i pulse -> valid_o=0.
REQ-035 SHALL check: frame 0x16 with parity 1 -> exactly one parity_err_o pulse, count_o=0.
REQ-036 SHALL check: with FIFO_DEPTH=8, frames 0x01..0x09 with no reads -> overflow_o=1, count_o=8; eight pops return 0x01..0x08; clr_i -> overflow_o=0.
REQ-037 SHALL check: a kclk_i low glitch of FILTER_LEN-1 cycles while in IDLE -> FSM stays IDLE; a following valid 0x1C frame is received as 0x1C.
REQ-038 SHALL check, with PS2_RX_TIMEOUT_EN defined: start bit plus 3 data bits then kclk_i held high -> one frame_err_o pulse TIMEOUT_CYCLES after the last edge; next frame 0x1C received correctly.
REQ-039 SHALL check: resetn=0 for 2 cycles after bit 4 of a frame -> count_o=0, no error pulses; next 0x16 frame received correctly.
